// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-port data RAM between the CPU MEM stage and an
// external loader/debug port, with round-robin fairness and an exclusive lock mode.
module ram_arbiter #(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  cpu_req,
    input  logic                  cpu_wren,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_gnt,
    output logic                  cpu_rvalid,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,

    input  logic                  ext_req,
    input  logic                  ext_wren,
    input  logic [ADDR_WIDTH-1:0] ext_addr,
    input  logic [DATA_WIDTH-1:0] ext_wdata,
    output logic                  ext_gnt,
    output logic                  ext_rvalid,
    output logic [DATA_WIDTH-1:0] ext_rdata,
    input  logic                  ext_lock,

    output logic                  lock_active,
    output logic                  lock_timeout,

    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_data
);

    typedef enum logic {
        ARB,
        LOCKED
    } state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_EXT = 1'b1;

    // The flag is armed one step early so it is visible in the same cycle the
    // counter reaches its last value.
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] TIMEOUT_ARM  = 16'(LOCK_TIMEOUT - 2);

    state_t                  state;
    state_t                  state_next;
    logic                    last_grant;
    logic                    grant_cpu;
    logic                    grant_ext;

    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;

    logic                    rd_pending;
    logic                    rd_owner;
    logic [DATA_WIDTH-1:0]   cpu_rdata_q;
    logic [DATA_WIDTH-1:0]   ext_rdata_q;

    logic [15:0]             wait_count;
    logic                    timeout_flag;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ARB;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ARB:     state_next = ext_lock ? LOCKED : ARB;
            LOCKED:  state_next = ext_lock ? LOCKED : ARB;
            default: state_next = ARB;
        endcase
    end

    // A CPU request is ignored whenever ext_lock is high, including the cycle
    // that enters LOCKED, so the lock takes effect without a stray CPU access.
    always_comb begin
        grant_cpu   = 1'b0;
        grant_ext   = 1'b0;
        lock_active = 1'b0;
        case (state)
            ARB: begin
                if (cpu_req && !ext_lock && ext_req) begin
                    if (last_grant == OWNER_EXT) begin
                        grant_cpu = 1'b1;
                    end else begin
                        grant_ext = 1'b1;
                    end
                end else if (cpu_req && !ext_lock) begin
                    grant_cpu = 1'b1;
                end else if (ext_req) begin
                    grant_ext = 1'b1;
                end
            end
            LOCKED: begin
                lock_active = 1'b1;
                grant_ext   = ext_req;
            end
            default: begin
                grant_cpu = 1'b0;
                grant_ext = 1'b0;
            end
        endcase
    end

    assign cpu_gnt   = grant_cpu;
    assign ext_gnt   = grant_ext;
    assign cpu_stall = cpu_req & ~grant_cpu;

    always_comb begin
        ram_wren       = 1'b0;
        ram_address    = addr_q;
        ram_write_data = wdata_q;
        if (grant_cpu) begin
            ram_wren       = cpu_wren;
            ram_address    = cpu_addr;
            ram_write_data = cpu_wdata;
        end else if (grant_ext) begin
            ram_wren       = ext_wren;
            ram_address    = ext_addr;
            ram_write_data = ext_wdata;
        end
    end

    // Leaving LOCKED hands priority back to the CPU, which has been starved.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= OWNER_EXT;
        end else if (state == LOCKED && !ext_lock) begin
            last_grant <= OWNER_EXT;
        end else if (grant_cpu) begin
            last_grant <= OWNER_CPU;
        end else if (grant_ext) begin
            last_grant <= OWNER_EXT;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant_cpu || grant_ext) begin
            addr_q  <= ram_address;
            wdata_q <= ram_write_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_pending <= 1'b0;
            rd_owner   <= OWNER_CPU;
        end else begin
            rd_pending <= (grant_cpu & ~cpu_wren) | (grant_ext & ~ext_wren);
            rd_owner   <= grant_ext ? OWNER_EXT : OWNER_CPU;
        end
    end

    assign cpu_rvalid = rd_pending && (rd_owner == OWNER_CPU);
    assign ext_rvalid = rd_pending && (rd_owner == OWNER_EXT);
    assign cpu_rdata  = cpu_rvalid ? ram_data : cpu_rdata_q;
    assign ext_rdata  = ext_rvalid ? ram_data : ext_rdata_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_rdata_q <= '0;
            ext_rdata_q <= '0;
        end else begin
            if (cpu_rvalid) begin
                cpu_rdata_q <= ram_data;
            end
            if (ext_rvalid) begin
                ext_rdata_q <= ram_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_count   <= '0;
            timeout_flag <= 1'b0;
        end else if (state == ARB || !cpu_req) begin
            wait_count <= '0;
        end else begin
            if (wait_count != TIMEOUT_LAST) begin
                wait_count <= wait_count + 16'd1;
            end
            if (wait_count == TIMEOUT_ARM) begin
                timeout_flag <= 1'b1;
            end
        end
    end

    assign lock_timeout = timeout_flag;

endmodule
